bip_result_sender: RTL

- Framing stage between the BIP core and uart_tx; replaces the ad-hoc send logic in the top level.
- On the BIP halt event it latches the accumulator and sends a header byte followed by the accumulator bytes, LSB first, to uart_tx.
- Uses the uart_tx start/done handshake.
- Reports busy/done so the top level or a LED can track transmission.

---
 rtl/bip_result_sender.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bip_result_sender.sv
// -----------------------------------------------------------------------------
// bip_result_sender
//
// Framing stage between the BIP core and uart_tx. On a rising edge of the BIP
// halt flag it latches the accumulator and sends a frame to uart_tx:
// HEADER, then ceil(NBITS_D/DBIT) accumulator bytes, LSB byte first. The top
// byte is zero-extended when NBITS_D is not a multiple of DBIT. Each byte goes
// through the uart_tx start/done handshake.
//
// Optional feature (macro BIP_RESULT_CHECKSUM_EN): one extra trailing byte,
// the XOR of HEADER and all data bytes, is appended to the frame.
//
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous active-high reset
//   i_halt      BIP halt flag (level); its rising edge triggers a frame
//   i_acc       BIP accumulator, latched at the trigger
//   i_tx_done   one-cycle done pulse from uart_tx
//   o_tx_start  one-cycle start pulse to uart_tx
//   o_tx_data   byte to transmit, stable from start until the matching done
//   o_busy      high while a frame is in progress
//   o_done      high after a complete frame, until i_halt falls
// -----------------------------------------------------------------------------
module bip_result_sender #(
  parameter int              NBITS_D = 16,
  parameter int              DBIT    = 8,
  parameter logic [DBIT-1:0] HEADER  = DBIT'(8'hA5)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic [NBITS_D-1:0] i_acc,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NBYTES = (NBITS_D + DBIT - 1) / DBIT;
  localparam int SHW    = NBYTES * DBIT;

  // Byte index: 0 is the header, 1..NBYTES the data bytes, NBYTES+1 the
  // checksum when enabled.
`ifdef BIP_RESULT_CHECKSUM_EN
  localparam int LAST_IDX = NBYTES + 1;
`else
  localparam int LAST_IDX = NBYTES;
`endif
  localparam int              IDXW = $clog2(LAST_IDX + 1);
  localparam logic [IDXW-1:0] LAST = IDXW'(LAST_IDX);
`ifdef BIP_RESULT_CHECKSUM_EN
  localparam logic [IDXW-1:0] DATA_LAST = IDXW'(NBYTES);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q,    state_d;
  logic              halt_dly_q, halt_dly_d;
  logic [SHW-1:0]    acc_sh_q,   acc_sh_d;   // latched accumulator, shifted out LSB first
  logic [IDXW-1:0]   idx_q,      idx_d;
  logic              tx_start_q, tx_start_d;
  logic [DBIT-1:0]   tx_data_q,  tx_data_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
`ifdef BIP_RESULT_CHECKSUM_EN
  logic [DBIT-1:0]   csum_q,     csum_d;     // running XOR of bytes loaded so far
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    halt_dly_d = i_halt;
    acc_sh_d   = acc_sh_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;           // start is a single-cycle pulse by default
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef BIP_RESULT_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // halt_dly resets to 0, so a halt already high at reset release
        // still reads as a rising edge.
        if (i_halt && !halt_dly_q) begin
          acc_sh_d                = '0;
          acc_sh_d[NBITS_D-1:0]   = i_acc;
          idx_d                   = '0;
          tx_data_d               = HEADER;
          tx_start_d              = 1'b1;
          busy_d                  = 1'b1;
`ifdef BIP_RESULT_CHECKSUM_EN
          csum_d                  = HEADER;
`endif
          state_d                 = S_WAIT;
        end
      end

      S_WAIT: begin
        // A done coincident with our own start pulse belongs to an older
        // transfer and is ignored.
        if (i_tx_done && !tx_start_q) begin
          if (idx_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d      = idx_q + IDXW'(1);
            tx_start_d = 1'b1;
`ifdef BIP_RESULT_CHECKSUM_EN
            if (idx_q == DATA_LAST) begin
              tx_data_d = csum_q;
            end else begin
              tx_data_d = acc_sh_q[DBIT-1:0];
              acc_sh_d  = acc_sh_q >> DBIT;
              csum_d    = csum_q ^ acc_sh_q[DBIT-1:0];
            end
`else
            tx_data_d  = acc_sh_q[DBIT-1:0];
            acc_sh_d   = acc_sh_q >> DBIT;
`endif
          end
        end
      end

      S_DONE: begin
        if (!i_halt) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      halt_dly_q <= 1'b0;
      acc_sh_q   <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BIP_RESULT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      halt_dly_q <= halt_dly_d;
      acc_sh_q   <= acc_sh_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BIP_RESULT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
